// File: rtl/factor_sequencer.sv
// Trial-division prime factorizer: drives a shared divide unit over req/ack and
// shows each prime factor for MAX_COUNT cycles. Define FACTOR_PRIME_FLAG_EN for the `prime` output.
module factor_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             div_req,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ack,
  input  logic [WIDTH-1:0] div_quot,
  input  logic             div_zero,
  output logic [WIDTH-1:0] factor,
  output logic             factor_valid,
  output logic             busy,
  output logic             done
`ifdef FACTOR_PRIME_FLAG_EN
  ,
  output logic             prime
`endif
);

  localparam int            CW       = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHOW, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   n, n_nx;
  logic [WIDTH-1:0]   d, d_nx;
  logic [WIDTH-1:0]   fac, fac_nx;
  logic               last, last_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [1:0]         nfac, nfac_nx;
  logic [2*WIDTH-1:0] d_sq;
  logic [1:0]         nfac_inc;

  assign d_sq     = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  // Only "exactly one factor" matters, so the count saturates at 2.
  assign nfac_inc = (nfac == 2'd2) ? nfac : nfac + 2'd1;

  always_comb begin
    state_nx = state;
    n_nx     = n;
    d_nx     = d;
    fac_nx   = fac;
    last_nx  = last;
    cnt_nx   = cnt;
    nfac_nx  = nfac;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          n_nx     = number;
          d_nx     = WIDTH'(2);
          last_nx  = 1'b0;
          nfac_nx  = 2'd0;
          state_nx = (number < WIDTH'(2)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (n == WIDTH'(1)) begin
          state_nx = DONE;
        end else if (d_sq > {{WIDTH{1'b0}}, n}) begin
          fac_nx   = n;
          last_nx  = 1'b1;
          nfac_nx  = nfac_inc;
          state_nx = SHOW;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (div_ack) begin
          if (div_zero) begin
            fac_nx   = d;
            n_nx     = div_quot;
            last_nx  = 1'b0;
            nfac_nx  = nfac_inc;
            state_nx = SHOW;
          end else begin
            d_nx     = d + WIDTH'(1);
            state_nx = ISSUE;
          end
        end
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = last ? DONE : ISSUE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      d     <= '0;
      fac   <= '0;
      last  <= 1'b0;
      cnt   <= '0;
      nfac  <= 2'd0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      d     <= d_nx;
      fac   <= fac_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      nfac  <= nfac_nx;
    end
  end

  // WAIT is entered only with operands latched, so req and operands are stable until ack.
  assign div_req      = (state == WAIT);
  assign div_dividend = n;
  assign div_divisor  = d;
  assign factor       = fac;
  assign factor_valid = (state == SHOW);
  assign busy         = (state == ISSUE) || (state == WAIT) || (state == SHOW);
  assign done         = (state == DONE);
`ifdef FACTOR_PRIME_FLAG_EN
  assign prime        = (state == DONE) && (nfac == 2'd1);
`endif

endmodule

// File: tb/tb_factor_sequencer.sv
// Directed bench for factor_sequencer with a randomly-delayed divide-unit model and a factor scoreboard.
module tb_factor_sequencer;
  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] number;
  logic       div_req;
  logic [7:0] div_dividend, div_divisor;
  logic       div_ack;
  logic [7:0] div_quot;
  logic       div_zero;
  logic [7:0] factor;
  logic       factor_valid, busy, done;
`ifdef FACTOR_PRIME_FLAG_EN
  logic       prime;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  bit hold_ack  = 1'b0;
  int stray_cnt = 0;
  int stray_seen;

  factor_sequencer #(.WIDTH(8), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .div_req(div_req), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ack(div_ack), .div_quot(div_quot), .div_zero(div_zero),
    .factor(factor), .factor_valid(factor_valid), .busy(busy), .done(done)
`ifdef FACTOR_PRIME_FLAG_EN
    , .prime(prime)
`endif
  );

  always #5 clk = ~clk;

  // Divide unit: answers a request after 0-3 cycles; can be stalled or made to emit a stray ack.
  initial begin
    int dly;
    bit armed;
    div_ack = 1'b0; div_quot = '0; div_zero = 1'b0;
    stray_seen = 0; armed = 1'b0; dly = 0;
    forever begin
      @(negedge clk);
      div_ack = 1'b0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        div_ack = 1'b1; div_quot = 8'd1; div_zero = 1'b1;
      end else if (div_req !== 1'b1 || rst) begin
        armed = 1'b0;
      end else if (!hold_ack) begin
        if (!armed) begin armed = 1'b1; dly = $urandom_range(0, 3); end
        if (dly == 0) begin
          div_ack  = 1'b1;
          div_quot = div_dividend / div_divisor;
          div_zero = (div_dividend % div_divisor) == 0;
          armed    = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] v);
    start = 1'b1; number = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs until done, popping expected factors at each rising factor_valid.
  task automatic collect(input int budget, input bit poke);
    int run, cyc;
    logic [7:0] cur, e;
    bit stab, poked;
    run = 0; cyc = 0; stab = 1'b1; poked = 1'b0; cur = '0;
    while (done !== 1'b1 && cyc < budget) begin
      if (factor_valid === 1'b1) begin
        if (run == 0) begin
          cur = factor;
          if (exp_q.size() == 0) check("factor_pending", 32'(exp_q.size() != 0), 1);
          else begin e = exp_q.pop_front(); check("factor", factor, e); end
        end else if (factor !== cur) begin
          stab = 1'b0;
        end
        run++;
        if (poke && run == 2 && !poked) begin start = 1'b1; number = 8'd99; poked = 1'b1; end
      end else if (run != 0) begin
        check("hold_len", run, MAXC);
        check("factor_stable", stab, 1);
        run = 0; stab = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (run != 0) begin
      check("hold_len", run, MAXC);
      check("factor_stable", stab, 1);
    end
    check("done_reached", done, 1);
    check("busy_in_done", busy, 0);
    check("valid_in_done", factor_valid, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    bit stable, saw_v, saw_r;
    rst = 1'b1; start = 1'b0; number = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {div_req, div_dividend, div_divisor, factor, factor_valid, busy, done}, 0);
`ifdef FACTOR_PRIME_FLAG_EN
    check("reset_prime", prime, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 12 -> 2, 2, 3
    exp_q.push_back(8'd2); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    start_op(8'd12);
    check("busy_after_start", busy, 1);
    collect(300, 1'b0);
`ifdef FACTOR_PRIME_FLAG_EN
    check("prime_12", prime, 0);
`endif

    // 255 -> 3, 5, 17
    exp_q.push_back(8'd3); exp_q.push_back(8'd5); exp_q.push_back(8'd17);
    start_op(8'd255);
    collect(500, 1'b0);

    // 13 with the divide unit stalled for 20 cycles on the first request
    hold_ack = 1'b1;
    exp_q.push_back(8'd13);
    start_op(8'd13);
    k = 0;
    while (div_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("req_seen", div_req, 1);
    stable = 1'b1;
    repeat (20) begin
      if (div_req !== 1'b1 || div_dividend !== 8'd13 || div_divisor !== 8'd2) stable = 1'b0;
      @(negedge clk);
    end
    check("stall_req_operands_stable", stable, 1);
    hold_ack = 1'b0;
    collect(300, 1'b0);
`ifdef FACTOR_PRIME_FLAG_EN
    check("prime_13", prime, 1);
`endif

    // 0 and 1 finish at once with no divide traffic and no factor
    for (int v = 0; v < 2; v++) begin
      start_op(8'(v));
      check("small_done_1cyc", done, 1);
      check("small_busy", busy, 0);
      saw_v = 1'b0; saw_r = 1'b0;
      repeat (3) begin
        if (factor_valid !== 1'b0) saw_v = 1'b1;
        if (div_req !== 1'b0) saw_r = 1'b1;
        @(negedge clk);
      end
      check("small_no_valid", saw_v, 0);
      check("small_no_req", saw_r, 0);
`ifdef FACTOR_PRIME_FLAG_EN
      check("small_prime", prime, 0);
`endif
    end

    // start pulse during SHOW is ignored
    exp_q.push_back(8'd2); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    start_op(8'd12);
    collect(300, 1'b1);

    // reset in WAIT, stray ack afterwards, then a fresh run of 6
    hold_ack = 1'b1;
    start_op(8'd12);
    k = 0;
    while (div_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("req_before_rst", div_req, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {div_req, div_dividend, div_divisor, factor, factor_valid, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_ack = 1'b0;
    stray_cnt++;
    repeat (3) @(negedge clk);
    check("stray_ack_ignored", {div_req, factor_valid, busy, done}, 0);
    exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    start_op(8'd6);
    collect(300, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
